lcd_spi_stream_ctrl: RTL

Parametrised ILI9341-class SPI panel controller: power-on reset, init command sequence, address window setup, then forwarding a byte stream of RGB565 pixel data to the panel. Sits between a pixel source (UART receiver, frame buffer reader or renderer) and the LCD pins. It replaces the fixed 240x320 UART-coupled controller. It adds a ready/valid input with backpressure, configurable geometry and SPI rate, and frame status outputs.

---
 rtl/lcd_spi_stream_ctrl_pkg.sv | 21 ++
 rtl/lcd_spi_stream_ctrl_if.sv | 8 +
 rtl/lcd_spi_stream_ctrl_byte_tx.sv | 77 +++++++
 rtl/lcd_spi_stream_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_spi_stream_ctrl_pkg.sv
// lcd_pkg: ILI9341 command set, sequencer state type and ROM entry layout.
package lcd_pkg;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] COLMOD_565  = 8'h55;
  localparam logic [4:0] INIT_LAST = 5'd9;
  localparam logic [4:0] WIN_FIRST = 5'd10;
  localparam logic [4:0] WIN_LAST  = 5'd20;
  typedef enum logic [2:0] {ST_RST_LO, ST_POST_RST, ST_INIT, ST_WINDOW, ST_STREAM} state_e;
  typedef struct packed {
    logic       gap;
    logic       dc;
    logic [7:0] data;
  } seq_t;
endpackage

// File: rtl/lcd_spi_stream_ctrl_if.sv
// lcd_spi_stream_ctrl_if: ready/valid byte stream from pixel source to controller.
interface lcd_spi_stream_ctrl_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  modport master (output s_data, s_valid, input s_ready);
  modport slave (input s_data, s_valid, output s_ready);
endinterface

// File: rtl/lcd_spi_stream_ctrl_byte_tx.sv
// lcd_spi_byte_tx: SPI mode 0 MSB-first byte shifter; CS low for 16*HALF_DIV cycles per byte.
module lcd_spi_byte_tx #(
  parameter int HALF_DIV = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       dc_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       sclk_o,
  output logic       cs_o,
  output logic       sdi_o,
  output logic       dc_o
);
  localparam int DW = HALF_DIV > 1 ? $clog2(HALF_DIV) : 1;
  logic [DW-1:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic busy_q, busy_d, done_q, done_d, sclk_q, sclk_d, dc_q, dc_d;
  logic half_end;
  assign half_end = div_q == DW'(HALF_DIV - 1);
  // Shifting on the falling edge leaves the register empty, so SDI idles low.
  always_comb begin
    div_d = '0;
    bit_d = bit_q;
    sh_d = sh_q;
    busy_d = busy_q;
    done_d = 1'b0;
    sclk_d = sclk_q;
    dc_d = dc_q;
    if (!busy_q && start_i) begin
      busy_d = 1'b1;
      sh_d = byte_i;
      dc_d = dc_i;
      bit_d = 3'd7;
      sclk_d = 1'b0;
    end else if (busy_q) begin
      div_d = half_end ? '0 : div_q + DW'(1);
      if (half_end) begin
        sclk_d = !sclk_q;
        if (sclk_q) begin
          sh_d = {sh_q[6:0], 1'b0};
          bit_d = bit_q - 3'd1;
          busy_d = bit_q != 3'd0;
          done_d = bit_q == 3'd0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sclk_q <= 1'b0;
      dc_q <= 1'b0;
    end else begin
      div_q <= div_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sclk_q <= sclk_d;
      dc_q <= dc_d;
    end
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sclk_o = sclk_q;
  assign cs_o = !busy_q;
  assign sdi_o = sh_q[7];
  assign dc_o = dc_q;
endmodule

// File: rtl/lcd_spi_stream_ctrl.sv
// lcd_spi_stream_ctrl: ILI9341 reset/init/window sequencer feeding a ready/valid pixel stream to SPI.
// Define LCD_FRAME_TIMEOUT_EN to abort a stalled frame after IDLE_TIMEOUT idle cycles.
module lcd_spi_stream_ctrl
  import lcd_pkg::*;
#(
  parameter int         H_RES          = 240,
  parameter int         V_RES          = 320,
  parameter int         SPI_HALF_DIV   = 7,
  parameter int         RESET_LOW_CYC  = 5_000_000,
  parameter int         POST_RESET_CYC = 20_000_000,
  parameter int         INIT_GAP_CYC   = 12_000_000,
  parameter logic [7:0] MADCTL         = 8'h08,
  parameter int         IDLE_TIMEOUT   = 5_000_000
) (
  input  logic clk,
  input  logic reset_p,
  lcd_spi_stream_ctrl_if.slave s,
  output logic init_done,
  output logic frame_done,
  output logic frame_abort,
  output logic lcd_reset,
  output logic lcd_cs,
  output logic lcd_dc,
  output logic lcd_sclk,
  output logic lcd_sdi,
  output logic lcd_bl
);
  localparam int TOTAL = 2 * H_RES * V_RES;
  localparam int BW = TOTAL > 1 ? $clog2(TOTAL) : 1;
  localparam logic [15:0] HM = 16'(H_RES - 1);
  localparam logic [15:0] VM = 16'(V_RES - 1);
  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0] idx_q, idx_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic init_done_q, init_done_d, lcd_reset_q, lcd_reset_d, last_q, last_d;
  logic tx_start, tx_dc, tx_busy, tx_done, adv, acc;
  logic [7:0] tx_byte;
  seq_t cur;
  // Indices 0..9 are the one-time init, 10..20 the per-frame window setup.
  always_comb begin
    case (idx_q)
      5'd0: cur = {1'b0, 1'b0, CMD_SWRESET};
      5'd1: cur = {1'b1, 1'b0, 8'h00};
      5'd2: cur = {1'b0, 1'b0, CMD_SLPOUT};
      5'd3: cur = {1'b1, 1'b0, 8'h00};
      5'd4: cur = {1'b0, 1'b0, CMD_MADCTL};
      5'd5: cur = {1'b0, 1'b1, MADCTL};
      5'd6: cur = {1'b0, 1'b0, CMD_COLMOD};
      5'd7: cur = {1'b0, 1'b1, COLMOD_565};
      5'd8: cur = {1'b0, 1'b0, CMD_DISPON};
      5'd9: cur = {1'b1, 1'b0, 8'h00};
      5'd10: cur = {1'b0, 1'b0, CMD_CASET};
      5'd11, 5'd12, 5'd16, 5'd17: cur = {1'b0, 1'b1, 8'h00};
      5'd13: cur = {1'b0, 1'b1, HM[15:8]};
      5'd14: cur = {1'b0, 1'b1, HM[7:0]};
      5'd15: cur = {1'b0, 1'b0, CMD_PASET};
      5'd18: cur = {1'b0, 1'b1, VM[15:8]};
      5'd19: cur = {1'b0, 1'b1, VM[7:0]};
      5'd20: cur = {1'b0, 1'b0, CMD_RAMWR};
      default: cur = '0;
    endcase
  end
  assign s.s_ready = state_q == ST_STREAM && !tx_busy;
  assign acc = s.s_valid && s.s_ready;
  assign adv = !tx_busy && (!cur.gap || cnt_q == 32'(INIT_GAP_CYC - 1));
`ifdef LCD_FRAME_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic abort_q, abort_d;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    byte_cnt_d = byte_cnt_q;
    init_done_d = init_done_q;
    lcd_reset_d = lcd_reset_q;
    last_d = last_q && !tx_done;
    tx_start = 1'b0;
    tx_byte = cur.data;
    tx_dc = cur.dc;
`ifdef LCD_FRAME_TIMEOUT_EN
    idle_d = '0;
    abort_d = 1'b0;
`endif
    case (state_q)
      ST_RST_LO: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'(RESET_LOW_CYC - 1)) begin
          cnt_d = '0;
          lcd_reset_d = 1'b1;
          state_d = ST_POST_RST;
        end
      end
      ST_POST_RST: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'(POST_RESET_CYC - 1)) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = ST_INIT;
        end
      end
      ST_INIT, ST_WINDOW: begin
        tx_start = !tx_busy && !cur.gap;
        if (!tx_busy && cur.gap) cnt_d = cnt_q + 32'd1;
        if (adv) begin
          cnt_d = '0;
          idx_d = idx_q + 5'd1;
          if (idx_q == INIT_LAST) begin
            state_d = ST_WINDOW;
            init_done_d = 1'b1;
          end
          if (idx_q == WIN_LAST) begin
            state_d = ST_STREAM;
            idx_d = WIN_FIRST;
          end
        end
      end
      ST_STREAM: begin
        tx_byte = s.s_data;
        tx_dc = 1'b1;
        tx_start = acc;
        if (acc) begin
          byte_cnt_d = byte_cnt_q + BW'(1);
          if (byte_cnt_q == BW'(TOTAL - 1)) begin
            byte_cnt_d = '0;
            last_d = 1'b1;
            state_d = ST_WINDOW;
          end
        end
`ifdef LCD_FRAME_TIMEOUT_EN
        else if (s.s_ready) begin
          idle_d = idle_q + 32'd1;
          if (idle_q == 32'(IDLE_TIMEOUT - 1)) begin
            idle_d = '0;
            abort_d = 1'b1;
            byte_cnt_d = '0;
            state_d = ST_WINDOW;
          end
        end else idle_d = idle_q;
`endif
      end
      default: state_d = ST_RST_LO;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= ST_RST_LO;
      cnt_q <= '0;
      idx_q <= '0;
      byte_cnt_q <= '0;
      init_done_q <= 1'b0;
      lcd_reset_q <= 1'b0;
      last_q <= 1'b0;
`ifdef LCD_FRAME_TIMEOUT_EN
      idle_q <= '0;
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      init_done_q <= init_done_d;
      lcd_reset_q <= lcd_reset_d;
      last_q <= last_d;
`ifdef LCD_FRAME_TIMEOUT_EN
      idle_q <= idle_d;
      abort_q <= abort_d;
`endif
    end
  end
`ifdef LCD_FRAME_TIMEOUT_EN
  assign frame_abort = abort_q;
`else
  logic unused_idle;
  assign unused_idle = |IDLE_TIMEOUT;
  assign frame_abort = 1'b0;
`endif
  lcd_spi_byte_tx #(.HALF_DIV(SPI_HALF_DIV)) u_tx (
    .clk(clk),
    .rst(reset_p),
    .start_i(tx_start),
    .byte_i(tx_byte),
    .dc_i(tx_dc),
    .busy_o(tx_busy),
    .done_o(tx_done),
    .sclk_o(lcd_sclk),
    .cs_o(lcd_cs),
    .sdi_o(lcd_sdi),
    .dc_o(lcd_dc)
  );
  assign frame_done = tx_done && last_q;
  assign init_done = init_done_q;
  assign lcd_reset = lcd_reset_q;
  assign lcd_bl = 1'b1;
endmodule
